// File: rtl/sa2_sched_pkg.sv
// sa2_sched_pkg: shared definitions for the 2x2 systolic-array job scheduler.
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - fixed array job length, default watchdog limit
//   - packed result bundle (c11, c12, c21, c22), 32 bits total
package sa2_sched_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned SA2_JOB_CYCLES    = 29;
   localparam int unsigned SA2_WDT_LIMIT_DEF = 40;
   localparam int unsigned SA2_RES_W         = 32;

   typedef struct packed {
      logic [7:0] c11;
      logic [7:0] c12;
      logic [7:0] c21;
      logic [7:0] c22;
   } sa2_res_t;

endpackage

// File: rtl/sa2_rr_arbiter.sv
// sa2_rr_arbiter: combinational round-robin pick.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  ID_W     index of the last winner; search starts at ptr+1
//   win_oh  out NUM_REQ  one-hot winner (0 when no request)
//   win_id  out ID_W     binary winner index (0 when no request)
//   any_req out 1        at least one request is set
module sa2_rr_arbiter
   import sa2_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [ID_W-1:0]    win_id,
   output logic               any_req
);

   logic            found;
   logic [ID_W-1:0] idx;

   // Scan offsets 1..NUM_REQ from ptr, so the previous winner is checked last.
   always_comb begin
      win_oh = '0;
      win_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = ID_W'((32'(ptr) + off) % NUM_REQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            win_oh[idx] = 1'b1;
            win_id      = idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/sa2_job_scheduler.sv
// sa2_job_scheduler: round-robin owner of one shared 2x2 systolic array.
// Grants one requester, holds active_sa2 until done_sa2, captures the four
// results and returns them tagged with the requester ID for one cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req        in  NUM_REQ    request levels, sampled only in IDLE
//   gnt        out NUM_REQ    one-hot grant, held for the whole job
//   gnt_id     out ID_W       binary grant index (operand mux select)
//   busy       out 1          high in RUN and DONE
//   active_sa2 out 1          array enable level (RUN only)
//   done_sa2   in  1          array completion pulse
//   c11_i..c22_i in 8         array results
//   res_valid  out 1          one-cycle result pulse (DONE)
//   res_id     out ID_W       owner of the result
//   res_c11..res_c22 out 8    captured results, held until next capture
// Optional (macro SA2_WDT_EN): watchdog over RUN with WDT_LIMIT cycles,
//   res_err out 1 (error flag qualified by res_valid),
//   sa_rst_o out 1 (one-cycle array reset pulse in a timed-out DONE).
module sa2_job_scheduler
   import sa2_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ID_W      = 2,
   parameter int unsigned WDT_LIMIT = SA2_WDT_LIMIT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               busy,
   output logic               active_sa2,
   input  logic               done_sa2,
   input  logic [7:0]         c11_i,
   input  logic [7:0]         c12_i,
   input  logic [7:0]         c21_i,
   input  logic [7:0]         c22_i,
   output logic               res_valid,
   output logic [ID_W-1:0]    res_id,
   output logic [7:0]         res_c11,
   output logic [7:0]         res_c12,
   output logic [7:0]         res_c21,
   output logic [7:0]         res_c22
`ifdef SA2_WDT_EN
   ,
   output logic               res_err,
   output logic               sa_rst_o
`endif
);

   if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
      $error("sa2_job_scheduler: NUM_REQ must be 2..8 and ID_W = clog2(NUM_REQ)");
   end
   if (WDT_LIMIT < 1 || WDT_LIMIT > 255) begin : g_bad_wdt
      $error("sa2_job_scheduler: WDT_LIMIT must fit the 8-bit watchdog counter");
   end

   logic [1:0]         state;
   logic [ID_W-1:0]    ptr;
   sa2_res_t           res_q;
   sa2_res_t           c_in;
   logic [NUM_REQ-1:0] win_oh;
   logic [ID_W-1:0]    win_id;
   logic               any_req;

   assign c_in = {c11_i, c12_i, c21_i, c22_i};

   sa2_rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W)
   ) u_arb (
      .req    (req),
      .ptr    (ptr),
      .win_oh (win_oh),
      .win_id (win_id),
      .any_req(any_req)
   );

`ifdef SA2_WDT_EN
   logic [7:0] wdt_cnt;
   logic       err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ptr    <= ID_W'(NUM_REQ - 1);
         gnt    <= '0;
         gnt_id <= '0;
         res_id <= '0;
         res_q  <= '0;
`ifdef SA2_WDT_EN
         wdt_cnt <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt    <= win_oh;
                  gnt_id <= win_id;
                  ptr    <= win_id;
                  state  <= ST_RUN;
`ifdef SA2_WDT_EN
                  wdt_cnt <= '0;
`endif
               end
            end
            ST_RUN: begin
               if (done_sa2) begin
                  res_q  <= c_in;
                  res_id <= gnt_id;
                  gnt    <= '0;
                  gnt_id <= '0;
                  state  <= ST_DONE;
`ifdef SA2_WDT_EN
                  err_q  <= 1'b0;
               end else if (wdt_cnt == 8'(WDT_LIMIT - 1)) begin
                  // Timeout on the last allowed RUN cycle: report an error
                  // with zeroed data and let DONE pulse the array reset.
                  res_q  <= '0;
                  res_id <= gnt_id;
                  gnt    <= '0;
                  gnt_id <= '0;
                  err_q  <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  wdt_cnt <= wdt_cnt + 8'd1;
`endif
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy       = (state == ST_RUN) || (state == ST_DONE);
   assign active_sa2 = (state == ST_RUN);
   assign res_valid  = (state == ST_DONE);
   assign res_c11    = res_q.c11;
   assign res_c12    = res_q.c12;
   assign res_c21    = res_q.c21;
   assign res_c22    = res_q.c22;

`ifdef SA2_WDT_EN
   assign res_err  = err_q;
   assign sa_rst_o = (state == ST_DONE) && err_q;
`endif

endmodule
